output_mem_if: RTL and testbench
================================

OUTPUT_MEM_IF -- requirements
Module: output_mem_if

Interface
REQ-001 Parameter N_MACS, default 4, number of MAC lanes (fixed at 4 by the lane ports).
REQ-002 Parameter DATA_W, default 16, signed output element width.
REQ-003 Parameter ACC_W, default 32, signed partial-sum width.
REQ-004 Parameter FRAC_W, default 8, fractional bits dropped during requantization.
REQ-005 Parameter MEM_DEPTH, default 256, number of output lines.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  acc_0..acc_3 carry a partial-sum beat this cycle.
REQ-009 in_last  in  1  final beat of the current output line; qualified by in_valid.
REQ-010 acc_0, acc_1, acc_2, acc_3  in  ACC_W each  signed partial sums from MAC lanes 0..3.
REQ-011 relu_en  in  1  clamp negative results to 0; sampled in QUANT.
REQ-012 rd_en  in  1  read request.
REQ-013 rd_addr  in  $clog2(MEM_DEPTH)  read line address.
REQ-014 rd_data  out  N_MACS*DATA_W  read line; lane 0 in LSBs.
REQ-015 rd_valid  out  1  rd_data valid.
REQ-016 wr_addr  out  $clog2(MEM_DEPTH)  next line to be written.
REQ-017 busy  out  1  state is not IDLE.
REQ-018 done  out  1  one-cycle pulse after a line is written.
REQ-019 overrun  out  1  sticky flag for a dropped beat.

Function
REQ-020 The state machine SHALL have four states: IDLE, ACCUM, QUANT, WRITE.
REQ-021 IDLE or ACCUM with in_valid SHALL add each acc_i into lane accumulator i (width ACC_W+4, sign-extended); the state goes to ACCUM, or to QUANT if in_last=1.
REQ-022 QUANT SHALL register, per lane: (sum + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic, round half up; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; then, if relu_en=1, replace negatives with 0.
REQ-023 WRITE SHALL write the packed line to mem[wr_addr] and clear all accumulators; wr_addr increments, wrapping from MEM_DEPTH-1 to 0; the state returns to IDLE.
REQ-024 Latency: in_last sampled at edge E0 -> memory and wr_addr updated at E2 -> done high from E2 to E3 only.
REQ-025 in_valid during QUANT or WRITE SHALL be dropped (no accumulation) and SHALL set overrun; overrun is cleared only by rst.
REQ-026 A new beat is accepted in the cycle done is high (state is IDLE).
REQ-027 Read SHALL be synchronous: rd_en at edge E drives rd_data = mem[rd_addr] and rd_valid=1 after E; rd_valid=0 otherwise and rd_data holds its last value.
REQ-028 A read and a write to the same address on the same edge SHALL return the old data (read-first).
REQ-029 Memory SHALL be block-RAM inferable with no reset on contents; contents are undefined until written.

Reset
REQ-030 rst SHALL, on the next edge, set state=IDLE, accumulators=0, wr_addr=0, done=0, overrun=0, rd_valid=0, rd_data=0.
REQ-031 rst mid-ACCUM or mid-QUANT SHALL discard the partial line with no memory write; rst during WRITE SHALL take priority, so the write does not occur.

Structure
REQ-032 The shared package SHALL hold DATA_W/ACC_W/FRAC_W defaults, the state encoding, and the saturate/round function.
REQ-033 A sub-module requant_lane SHALL implement the round, saturate and ReLU step for one lane; it SHALL be instantiated N_MACS times.

Verification
REQ-034 One beat, all lanes 0x00000180, in_last=1, relu_en=0 -> line 0 holds 0x0002 in each lane; done at E2; wr_addr=1.
REQ-035 Beats lane0 = 0x100, 0x200, 0x300, with in_last on the third beat -> lane0 result 0x0006.
REQ-036 Beats lane0 = 0x7FFFFFFF twice -> 0x7FFF; lane1 = 0x80000000 twice -> 0x8000.
REQ-037 lane0 = 0xFFFFFF00 -> 0xFFFF with relu_en=0 and 0x0000 with relu_en=1.
REQ-038 Write 256 lines -> wr_addr wraps to 0; the 257th line overwrites line 0; read of line 0 in the same cycle as that write returns the old line.
REQ-039 in_valid in QUANT -> that beat is not accumulated and overrun=1; assert rst during ACCUM -> no write occurs and wr_addr is unchanged.

Source files
------------

// File: rtl/output_mem_if_pkg.sv
// output_mem_if_pkg: shared widths, FSM encoding and requantization helper
// Exports DATA_W/ACC_W/FRAC_W defaults, state_t and round_sat().
package output_mem_if_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int FRAC_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, QUANT, WRITE} state_t;
    // Round half up via bias then arithmetic shift, then clamp to the signed data_w range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] sum, input int frac_w, input int data_w);
        logic signed [63:0] r, hi, lo;
        r  = (sum + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return r > hi ? hi : r < lo ? lo : r;
    endfunction
endpackage

// File: rtl/output_mem_if_if.sv
// output_mem_if_if: beat input, read port and status bundle of output_mem_if
// master drives in_valid/in_last/acc_0..3/relu_en/rd_en/rd_addr; slave drives
// rd_data/rd_valid/wr_addr/busy/done/overrun.
interface output_mem_if_if import output_mem_if_pkg::*; #(
    parameter int N_MACS    = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);
    logic                         in_valid;
    logic                         in_last;
    logic signed [ACC_W-1:0]      acc_0;
    logic signed [ACC_W-1:0]      acc_1;
    logic signed [ACC_W-1:0]      acc_2;
    logic signed [ACC_W-1:0]      acc_3;
    logic                         relu_en;
    logic                         rd_en;
    logic [AW-1:0]                rd_addr;
    logic [N_MACS*DATA_W-1:0]     rd_data;
    logic                         rd_valid;
    logic [AW-1:0]                wr_addr;
    logic                         busy;
    logic                         done;
    logic                         overrun;
    modport master (
        output in_valid, in_last, acc_0, acc_1, acc_2, acc_3, relu_en, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_addr, busy, done, overrun
    );
    modport slave (
        input  in_valid, in_last, acc_0, acc_1, acc_2, acc_3, relu_en, rd_en, rd_addr,
        output rd_data, rd_valid, wr_addr, busy, done, overrun
    );
endinterface

// File: rtl/requant_lane.sv
// requant_lane: round, saturate and optional ReLU of one lane accumulator
// sum: ACC_W+4 signed accumulator; relu_en: zero negatives; q: DATA_W result.
module requant_lane import output_mem_if_pkg::*; #(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic signed [ACC_W+3:0] sum,
    input  logic                    relu_en,
    output logic [DATA_W-1:0]       q
);
    logic signed [63:0] r;
    always_comb begin
        r = round_sat(64'(sum), FRAC_W, DATA_W);
        q = relu_en && r < 0 ? '0 : DATA_W'(r);
    end
endmodule

// File: rtl/output_mem_if.sv
// output_mem_if: accumulates MAC partial sums per line, requantizes and stores lines in RAM
// clk/rst: clock and sync active-high reset; bus: beat input, synchronous
// read port, and wr_addr/busy/done/overrun status.
module output_mem_if import output_mem_if_pkg::*; #(
    parameter int N_MACS    = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int MEM_DEPTH = 256
) (
    input logic            clk,
    input logic            rst,
    output_mem_if_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int SW = ACC_W + 4;
    localparam int LW = N_MACS * DATA_W;
    state_t                  state, state_n;
    logic                    accept;
    logic signed [ACC_W-1:0] in_acc [N_MACS];
    logic signed [SW-1:0]    acc_q [N_MACS];
    logic [DATA_W-1:0]       q_lane [N_MACS];
    logic [LW-1:0]           line_n, line_q;
    logic [LW-1:0]           mem [MEM_DEPTH];
    assign in_acc[0] = bus.acc_0;
    assign in_acc[1] = bus.acc_1;
    assign in_acc[2] = bus.acc_2;
    assign in_acc[3] = bus.acc_3;
    assign accept    = bus.in_valid && (state == IDLE || state == ACCUM);
    assign bus.busy  = state != IDLE;
    always_comb
        state_n = state == QUANT ? WRITE : state == WRITE ? IDLE : !accept ? state : bus.in_last ? QUANT : ACCUM;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_ff @(posedge clk)
        for (int i = 0; i < N_MACS; i++)
            acc_q[i] <= rst || state == WRITE ? '0 : accept ? acc_q[i] + SW'(in_acc[i]) : acc_q[i];
    genvar l;
    generate
        for (l = 0; l < N_MACS; l++) begin : g_lane
            requant_lane #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
                .sum(acc_q[l]),
                .relu_en(bus.relu_en),
                .q(q_lane[l])
            );
            assign line_n[l*DATA_W +: DATA_W] = q_lane[l];
        end
    endgenerate
    always_ff @(posedge clk)
        if (state == QUANT) line_q <= line_n;
    always_ff @(posedge clk)
        if (rst) begin
            bus.wr_addr <= '0;
            bus.done    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.done    <= state == WRITE;
            bus.overrun <= bus.overrun || (bus.in_valid && !accept);
            if (state == WRITE) bus.wr_addr <= bus.wr_addr == AW'(MEM_DEPTH - 1) ? '0 : bus.wr_addr + 1'b1;
        end
    // No reset on contents; rst only gates the write enable so a reset in WRITE drops the line.
    always_ff @(posedge clk)
        if (!rst && state == WRITE) mem[bus.wr_addr] <= line_q;
    // Nonblocking read of the array gives read-first behaviour on a same-address write.
    always_ff @(posedge clk)
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        end
endmodule

// File: tb/tb_output_mem_if.sv
// tb_output_mem_if: table, directed and random checks of output_mem_if against a reference model
module tb_output_mem_if;
    typedef struct {
        logic [3:0][31:0] a;
        bit               last;
        bit               relu;
        logic [63:0]      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    output_mem_if_if bus();
    output_mem_if dut (.clk(clk), .rst(rst), .bus(bus));

    int          errors = 0;
    int          checks = 0;
    longint      sum [4];
    logic [63:0] mm [256];
    int          wr = 0;
    bit          relu = 0;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_lane(input longint s, input bit rl);
        longint n, r;
        n = s + 128;
        r = n / 256;
        if (n % 256 != 0 && n < 0) r = r - 1;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (rl && r < 0) r = 0;
        return r[15:0];
    endfunction

    function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3, input bit last, rl, input logic [63:0] exp);
        vec_t v;
        v.a = {a3, a2, a1, a0};
        v.last = last;
        v.relu = rl;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] rnd();
        return $urandom_range(3) == 0 ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
    endfunction

    task automatic clear_model;
        for (int i = 0; i < 4; i++) sum[i] = 0;
    endtask

    task automatic beat(input logic [3:0][31:0] a, input bit last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.acc_0 = a[0];
        bus.acc_1 = a[1];
        bus.acc_2 = a[2];
        bus.acc_3 = a[3];
        for (int i = 0; i < 4; i++) sum[i] += longint'($signed(a[i]));
        tick;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the in_last beat edge; junk drives beats during QUANT/WRITE,
    // rd0 reads the target address on the same edge as the write.
    task automatic finish(output logic [63:0] line, input bit junk, input bit rd0);
        logic [63:0] old;
        for (int i = 0; i < 4; i++) line[i*16 +: 16] = ref_lane(sum[i], relu);
        clear_model();
        old = mm[wr];
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.acc_0 = 32'h0001_0000;
        end
        tick;
        chk("done_e1", 64'(bus.done), 64'd0);
        chk("busy_e1", 64'(bus.busy), 64'd1);
        if (rd0) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = 8'(wr);
        end
        tick;
        bus.in_valid = 1'b0;
        bus.rd_en = 1'b0;
        mm[wr] = line;
        wr = (wr + 1) % 256;
        chk("done_e2", 64'(bus.done), 64'd1);
        chk("wr_addr", 64'(bus.wr_addr), 64'(wr));
        if (rd0) chk("read_first", bus.rd_data, old);
    endtask

    task automatic rd(input int addr, input logic [63:0] exp);
        bus.rd_en = 1'b1;
        bus.rd_addr = 8'(addr);
        tick;
        bus.rd_en = 1'b0;
        chk("rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("rd_data", bus.rd_data, exp);
        tick;
        chk("rd_valid_low", 64'(bus.rd_valid), 64'd0);
        chk("rd_hold", bus.rd_data, exp);
    endtask

    initial begin
        vec_t tbl [10];
        logic [63:0] line;
        logic [3:0][31:0] a;
        int nb, target;
        tbl[0] = mk(32'h180, 32'h180, 32'h180, 32'h180, 1, 0, 64'h0002_0002_0002_0002);
        tbl[1] = mk(32'h100, 0, 0, 0, 0, 0, 64'h0);
        tbl[2] = mk(32'h200, 0, 0, 0, 0, 0, 64'h0);
        tbl[3] = mk(32'h300, 0, 0, 0, 1, 0, 64'h0000_0000_0000_0006);
        tbl[4] = mk(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 64'h0);
        tbl[5] = mk(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 1, 0, 64'h0000_0000_8000_7FFF);
        tbl[6] = mk(32'hFFFF_FF00, 0, 0, 0, 1, 0, 64'h0000_0000_0000_FFFF);
        tbl[7] = mk(32'hFFFF_FF00, 0, 0, 0, 1, 1, 64'h0000_0000_0000_0000);
        tbl[8] = mk(32'h80, 32'h7F, 32'hFFFF_FF80, 32'hFFFF_FF7F, 1, 0, 64'hFFFF_0000_0000_0001);
        tbl[9] = mk(32'h80, 32'hFFFF_FF00, 32'h400, 32'hFFFF_0000, 1, 1, 64'h0000_0004_0000_0001);
        bus.in_valid = 0; bus.in_last = 0; bus.relu_en = 0; bus.rd_en = 0; bus.rd_addr = 0;
        bus.acc_0 = 0; bus.acc_1 = 0; bus.acc_2 = 0; bus.acc_3 = 0;
        clear_model();
        tick;
        tick;
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);

        a = {32'h0, 32'h0, 32'h0, 32'h5000};
        beat(a, 0);
        chk("accum_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_model();
        chk("rst_accum_busy", 64'(bus.busy), 64'd0);
        chk("rst_accum_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_accum_done", 64'(bus.done), 64'd0);

        for (int k = 0; k < 10; k++) begin
            relu = tbl[k].relu;
            bus.relu_en = relu;
            beat(tbl[k].a, tbl[k].last);
            if (tbl[k].last) begin
                finish(line, 0, 0);
                rd((wr + 255) % 256, tbl[k].exp);
            end
        end

        relu = 0;
        bus.relu_en = 0;
        chk("overrun_clear", 64'(bus.overrun), 64'd0);
        a = {32'h0, 32'h0, 32'h0, 32'h100};
        beat(a, 1);
        finish(line, 1, 0);
        chk("overrun_set", 64'(bus.overrun), 64'd1);
        rd((wr + 255) % 256, 64'h1);
        beat(a, 1);
        finish(line, 0, 0);
        rd((wr + 255) % 256, 64'h1);
        chk("overrun_sticky", 64'(bus.overrun), 64'd1);

        for (int n = 0; n < 30; n++) begin
            nb = $urandom_range(1, 4);
            relu = 1'($urandom_range(1));
            bus.relu_en = relu;
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 4; i++) a[i] = rnd();
                beat(a, b == nb - 1);
            end
            finish(line, 0, 0);
            if ($urandom_range(1) == 1) rd((wr + 255) % 256, line);
        end

        while (wr != 0) begin
            for (int i = 0; i < 4; i++) a[i] = rnd();
            beat(a, 1);
            finish(line, 0, 0);
        end
        for (int i = 0; i < 4; i++) a[i] = rnd();
        beat(a, 1);
        finish(line, 0, 1);
        rd(0, line);

        target = wr;
        a = {32'h1000, 32'h1000, 32'h1000, 32'h1000};
        beat(a, 1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_model();
        wr = 0;
        chk("rst_write_done", 64'(bus.done), 64'd0);
        chk("rst_write_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_write_busy", 64'(bus.busy), 64'd0);
        rd(target, mm[target]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
